// File: rtl/alu_result_accumulator_if.sv
// Handshake bundle between the ALU stage, the result accumulator and the sum consumer.
// Producer/consumer side uses the master modport; the accumulator uses slave.
interface alu_result_accumulator_if #(
  parameter int NBITS  = 15,
  parameter int NTERMS = 8,
  parameter int ACCW   = 24
);
  localparam int YW = NBITS + 2;
  localparam int CW = $clog2(NTERMS + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic signed [YW-1:0] Y;
  logic                 co;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACCW-1:0]      acc_out;
  logic                 ovf;
  logic                 co_seen;
  logic [CW-1:0]        count;

  modport master (
    output in_valid, Y, co, out_ready,
    input  in_ready, out_valid, acc_out, ovf, co_seen, count
  );

  modport slave (
    input  in_valid, Y, co, out_ready,
    output in_ready, out_valid, acc_out, ovf, co_seen, count
  );
endinterface

// File: rtl/alu_result_accumulator.sv
// Sums NTERMS signed ALU results into a saturating accumulator and hands off each sum.
// Define ACC_RELU_EN to clamp negative finished sums to zero on acc_out.
module alu_result_accumulator #(
  parameter int NBITS  = 15,
  parameter int NTERMS = 8,
  parameter int ACCW   = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  alu_result_accumulator_if.slave bus
);
  localparam int YW = NBITS + 2;
  localparam int CW = $clog2(NTERMS + 1);
  localparam logic [ACCW-1:0] MAXV = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] MINV = {1'b1, {(ACCW-1){1'b0}}};

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t          state;
  logic [ACCW-1:0] acc;
  logic [CW-1:0]   count;
  logic            out_valid;
  logic [ACCW-1:0] acc_out;
  logic            ovf;
  logic            co_seen;

  logic            in_ready;
  logic            accept;
  logic            last;
  logic [ACCW:0]   sum_wide;
  logic            add_ovf;
  logic [ACCW-1:0] sat_sum;
  logic [ACCW-1:0] final_sum;

  assign in_ready = (state == ACCUM) && !clear;
  assign accept   = bus.in_valid && in_ready;
  assign last     = (count == CW'(NTERMS - 1));

  // One guard bit: the sum overflowed iff the two top bits disagree.
  assign sum_wide = {acc[ACCW-1], acc} + {{(ACCW+1-YW){bus.Y[YW-1]}}, bus.Y};
  assign add_ovf  = sum_wide[ACCW] ^ sum_wide[ACCW-1];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sat_sum = sum_wide[ACCW-1:0];
    if (add_ovf) sat_sum = sum_wide[ACCW] ? MINV : MAXV;
  end

`ifdef ACC_RELU_EN
  assign final_sum = sat_sum[ACCW-1] ? '0 : sat_sum;
`else
  assign final_sum = sat_sum;
`endif

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      acc_out   <= '0;
      ovf       <= 1'b0;
      co_seen   <= 1'b0;
    end else if (clear) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      acc_out   <= '0;
      ovf       <= 1'b0;
      co_seen   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            co_seen <= co_seen | bus.co;
            ovf     <= ovf | add_ovf;
            if (last) begin
              acc_out   <= final_sum;
              acc       <= '0;
              count     <= '0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              acc   <= sat_sum;
              count <= count + CW'(1);
            end
          end
        end
        HOLD: begin
          // Batch flags live until the consumer takes the sum.
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            co_seen   <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.acc_out   = acc_out;
  assign bus.ovf       = ovf;
  assign bus.co_seen   = co_seen;
  assign bus.count     = count;
endmodule
